// File: rtl/fifo_stream_drain_if.sv
// FIFO read port plus outgoing valid/ready stream of the drain block.
// master = the drain, slave = the FIFO/stream environment.
interface fifo_stream_drain_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_stream_drain.sv
// Pops a show-ahead FIFO into a registered valid/ready stream, framing beats into
// bursts of a programmable length and keeping beat/burst/stall statistics.
module fifo_stream_drain #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [LEN_WIDTH-1:0] cfg_burst_len,
   input  logic                 cnt_clear,
   fifo_stream_drain_if.master  bus,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] beat_count,
   output logic [CNT_WIDTH-1:0] burst_count,
   output logic [CNT_WIDTH-1:0] stall_count
);

   typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

   state_e                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
   logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
   logic                  head_last_q, head_last_d;
   logic                  tail_last_q, tail_last_d;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, burst_cnt_q, stall_cnt_q;

   logic                  pop, accept, stall, pop_last;
   logic [LEN_WIDTH-1:0]  cfg_len, cur_len;

   assign cfg_len  = (cfg_burst_len == '0) ? LEN_WIDTH'(1) : cfg_burst_len;
   // A burst uses the length sampled on its first pop; later cfg changes wait.
   assign cur_len  = (idx_q == '0) ? cfg_len : len_q;
   assign pop_last = (idx_q == cur_len - LEN_WIDTH'(1));

   assign pop    = (state_q != StIdle) && !bus.fifo_empty && (occ_q != 2'd2);
   assign accept = bus.m_valid && bus.m_ready;
   assign stall  = bus.m_valid && !bus.m_ready;

   assign bus.fifo_rd_en = pop;
   assign bus.m_valid    = (occ_q != 2'd0);
   assign bus.m_data     = head_data_q;
   assign bus.m_last     = head_last_q;

   assign busy        = (state_q != StIdle) || (occ_q != 2'd0);
   assign beat_count  = beat_cnt_q;
   assign burst_count = burst_cnt_q;
   assign stall_count = stall_cnt_q;

   always_comb begin
      idx_d = idx_q;
      len_d = len_q;
      if (pop) begin
         if (idx_q == '0) begin
            len_d = cfg_len;
         end
         idx_d = pop_last ? '0 : idx_q + LEN_WIDTH'(1);
      end
   end

   // Two-entry skid: head drives the stream, tail only fills while head is stalled.
   always_comb begin
      occ_d       = occ_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      tail_data_d = tail_data_q;
      tail_last_d = tail_last_q;
      unique case (occ_q)
         2'd0: begin
            if (pop) begin
               head_data_d = bus.fifo_data;
               head_last_d = pop_last;
               occ_d       = 2'd1;
            end
         end
         2'd1: begin
            if (pop && accept) begin
               head_data_d = bus.fifo_data;
               head_last_d = pop_last;
            end else if (pop) begin
               tail_data_d = bus.fifo_data;
               tail_last_d = pop_last;
               occ_d       = 2'd2;
            end else if (accept) begin
               occ_d = 2'd0;
            end
         end
         2'd2: begin
            if (accept) begin
               head_data_d = tail_data_q;
               head_last_d = tail_last_q;
               occ_d       = 2'd1;
            end
         end
         default: occ_d = 2'd0;
      endcase
   end

   // Stopping waits for the post-pop index to reach a burst boundary.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StRun;
         end
         StRun: begin
            if (!enable) state_d = (idx_d == '0) ? StIdle : StFinish;
         end
         StFinish: begin
            if (enable) begin
               state_d = StRun;
            end else if (idx_d == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         occ_q       <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         tail_data_q <= '0;
         tail_last_q <= 1'b0;
         idx_q       <= '0;
         len_q       <= LEN_WIDTH'(1);
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         tail_data_q <= tail_data_d;
         tail_last_q <= tail_last_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (cnt_clear) begin
         beat_cnt_q  <= '0;
         burst_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept)                beat_cnt_q  <= beat_cnt_q + CNT_WIDTH'(1);
         if (accept && head_last_q) burst_cnt_q <= burst_cnt_q + CNT_WIDTH'(1);
         if (stall)                 stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a queue-based FIFO, an expected beat stream tagged by
// burst position, vector table, hand-written corner sequences and a random phase.
module tb_fifo_stream_drain;

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          cnt_clear;
   logic [LW-1:0] cfg_burst_len;
   logic          busy;
   logic [CW-1:0] beat_count;
   logic [CW-1:0] burst_count;
   logic [CW-1:0] stall_count;

   fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_drain #(
      .DATA_WIDTH (DW),
      .LEN_WIDTH  (LW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .cfg_burst_len (cfg_burst_len),
      .cnt_clear     (cnt_clear),
      .bus           (bus),
      .busy          (busy),
      .beat_count    (beat_count),
      .burst_count   (burst_count),
      .stall_count   (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      int len;
      int nwords;
      int rmode;
      int exp_beats;
      int exp_bursts;
   } vec_t;

   logic [DW-1:0] fifo_q[$];
   beat_t         exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            occ, n_pops, n_acc, cyc, first_acc, last_acc;
   int            m_pos, m_len;
   logic [CW-1:0] m_beats, m_bursts, m_stalls;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic drive_fifo();
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
   endtask

   // Tag by position in the expected output stream: every L-th beat closes a burst.
   task automatic push(input logic [DW-1:0] w);
      beat_t b;
      if (m_pos == 0) m_len = (cfg_burst_len == '0) ? 1 : int'(cfg_burst_len);
      b.data = w;
      b.last = (m_pos + 1 == m_len);
      m_pos  = b.last ? 0 : m_pos + 1;
      fifo_q.push_back(w);
      exp_q.push_back(b);
      drive_fifo();
   endtask

   task automatic push_tag(input logic [DW-1:0] w, input logic last);
      beat_t b;
      b.data = w;
      b.last = last;
      fifo_q.push_back(w);
      exp_q.push_back(b);
      drive_fifo();
   endtask

   task automatic observe();
      logic  rd, r, mv, acc;
      beat_t b;
      rd  = bus.fifo_rd_en;
      r   = bus.m_ready;
      mv  = (occ != 0);
      acc = mv && r;
      b   = '0;
      cyc++;
      check("valid_vs_occupancy", {63'd0, bus.m_valid}, {63'd0, mv});
      if (rd) begin
         check("pop_when_nonempty", {63'd0, bus.fifo_empty}, 64'd0);
         check("pop_below_two", {63'd0, (occ < 2)}, 64'd1);
      end
      if (bus.m_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {63'd0, bus.m_valid}, 64'd0);
         end else begin
            check("m_data", {32'd0, bus.m_data}, {32'd0, exp_q[0].data});
            check("m_last", {63'd0, bus.m_last}, {63'd0, exp_q[0].last});
         end
      end
      if (acc && exp_q.size() != 0) begin
         b = exp_q.pop_front();
         n_acc++;
         if (n_acc == 1) first_acc = cyc;
         last_acc = cyc;
      end
      occ = occ + int'(rd) - int'(acc);
      if (rd) n_pops++;
      if (cnt_clear) begin
         m_beats  = '0;
         m_bursts = '0;
         m_stalls = '0;
      end else begin
         if (acc) m_beats = m_beats + 1;
         if (acc && b.last) m_bursts = m_bursts + 1;
         if (mv && !r) m_stalls = m_stalls + 1;
      end
   endtask

   task automatic step();
      logic pend_pop;
      @(negedge clk);
      observe();
      pend_pop = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (pend_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      drive_fifo();
   endtask

   task automatic drain(input string name, input int budget, input int rmode);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         if (rmode == 0)      bus.m_ready = 1'b1;
         else if (rmode == 1) bus.m_ready = (n % 3 == 0);
         else                 bus.m_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      bus.m_ready = 1'b1;
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_counters(input string name);
      check({name, "_beat_count"}, {32'd0, beat_count}, {32'd0, m_beats});
      check({name, "_burst_count"}, {32'd0, burst_count}, {32'd0, m_bursts});
      check({name, "_stall_count"}, {32'd0, stall_count}, {32'd0, m_stalls});
   endtask

   task automatic check_quiet(input string name);
      check({name, "_rd_en"}, {63'd0, bus.fifo_rd_en}, 64'd0);
      check({name, "_m_valid"}, {63'd0, bus.m_valid}, 64'd0);
      check({name, "_m_last"}, {63'd0, bus.m_last}, 64'd0);
      check({name, "_m_data"}, {32'd0, bus.m_data}, 64'd0);
      check({name, "_busy"}, {63'd0, busy}, 64'd0);
      check({name, "_beats"}, {32'd0, beat_count}, 64'd0);
      check({name, "_bursts"}, {32'd0, burst_count}, 64'd0);
      check({name, "_stalls"}, {32'd0, stall_count}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      enable      = 1'b0;
      cnt_clear   = 1'b0;
      bus.m_ready = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      drive_fifo();
      occ = 0; n_pops = 0; n_acc = 0; cyc = 0; first_acc = 0; last_acc = 0;
      m_pos = 0; m_len = 1;
      m_beats = '0; m_bursts = '0; m_stalls = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, want finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs[6];
      bit   [7:0] lastpat;
      int         n;
      logic [DW-1:0] nextw;

      vecs[0] = '{4,   8, 0, 8, 2};
      vecs[1] = '{2,   6, 1, 6, 3};
      vecs[2] = '{0,   5, 0, 5, 5};
      vecs[3] = '{1,   3, 1, 3, 3};
      vecs[4] = '{3,   7, 2, 7, 2};
      vecs[5] = '{255, 4, 0, 4, 0};

      cfg_burst_len = LW'(4);
      rst_n = 1'b0;
      do_reset();
      check_quiet("reset");

      // Vector table: preload, enable, drain, compare totals.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         cfg_burst_len = LW'(vecs[i].len);
         for (int k = 0; k < vecs[i].nwords; k++) push(DW'(32'h10 + k));
         enable = 1'b1;
         drain($sformatf("vec%0d", i), 80, vecs[i].rmode);
         repeat (2) step();
         check($sformatf("vec%0d_beats", i), {32'd0, beat_count}, 64'(vecs[i].exp_beats));
         check($sformatf("vec%0d_bursts", i), {32'd0, burst_count}, 64'(vecs[i].exp_bursts));
         check_counters($sformatf("vec%0d", i));
         if (vecs[i].rmode == 0) begin
            check($sformatf("vec%0d_stalls", i), {32'd0, stall_count}, 64'd0);
            check($sformatf("vec%0d_back_to_back", i), 64'(last_acc - first_acc),
                  64'(vecs[i].nwords - 1));
         end
      end

      // Graceful stop after the second pop of a 4-beat burst.
      do_reset();
      cfg_burst_len = LW'(4);
      for (int k = 0; k < 10; k++) push(DW'(k));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (n_pops < 2 && n < 20) begin step(); n++; end
      check("stop_two_pops", 64'(n_pops), 64'd2);
      enable = 1'b0;
      for (int j = 0; j < 12; j++) begin
         step();
         if (j >= 4) check("stop_rd_en_low", {63'd0, bus.fifo_rd_en}, 64'd0);
      end
      check("stop_beats", {32'd0, beat_count}, 64'd4);
      check("stop_bursts", {32'd0, burst_count}, 64'd1);
      check("stop_fifo_left", 64'(fifo_q.size()), 64'd6);
      check("stop_busy", {63'd0, busy}, 64'd0);

      // Length change 4 -> 2 after the first beat: tags at beats 4, 6, 8.
      do_reset();
      cfg_burst_len = LW'(4);
      lastpat = 8'b1010_1000;
      for (int k = 0; k < 8; k++) push_tag(DW'(32'h20 + k), lastpat[k]);
      bus.m_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (n_acc < 1 && n < 20) begin step(); n++; end
      cfg_burst_len = LW'(2);
      drain("lenchg", 40, 0);
      step();
      check("lenchg_bursts", {32'd0, burst_count}, 64'd3);

      // FIFO empty for 5 cycles inside a 3-beat burst.
      do_reset();
      cfg_burst_len = LW'(3);
      push(DW'(32'h30));
      push(DW'(32'h31));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (n_acc < 2 && n < 20) begin step(); n++; end
      for (int j = 0; j < 5; j++) begin
         step();
         check("gap_valid_low", {63'd0, bus.m_valid}, 64'd0);
      end
      check("gap_busy", {63'd0, busy}, 64'd1);
      push(DW'(32'h32));
      drain("gap", 20, 0);
      step();
      check("gap_bursts", {32'd0, burst_count}, 64'd1);
      check("gap_beats", {32'd0, beat_count}, 64'd3);

      // Asynchronous reset mid-burst with both skid entries full.
      do_reset();
      cfg_burst_len = LW'(4);
      for (int k = 0; k < 6; k++) push(DW'(32'h40 + k));
      bus.m_ready = 1'b0;
      enable = 1'b1;
      n = 0;
      while (occ < 2 && n < 20) begin step(); n++; end
      check("rst_occ_two", 64'(occ), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("async_rst");
      do_reset();
      cfg_burst_len = LW'(4);
      for (int k = 0; k < 4; k++) push(DW'(32'h50 + k));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      drain("post_rst", 20, 0);
      step();
      check("post_rst_bursts", {32'd0, burst_count}, 64'd1);

      // cnt_clear coinciding with an accepted (last) beat.
      do_reset();
      cfg_burst_len = LW'(2);
      for (int k = 0; k < 4; k++) push(DW'(32'h60 + k));
      bus.m_ready = 1'b1;
      enable = 1'b1;
      n = 0;
      while (!(n_acc >= 1 && bus.m_valid) && n < 20) begin step(); n++; end
      check("clr_beat_before", {32'd0, beat_count}, 64'd1);
      cnt_clear = 1'b1;
      step();
      cnt_clear = 1'b0;
      check("clr_beat_zero", {32'd0, beat_count}, 64'd0);
      check("clr_burst_zero", {32'd0, burst_count}, 64'd0);
      drain("clr", 20, 0);
      step();
      check_counters("clr");

      // Random traffic, enable toggling, backpressure and sporadic counter clears.
      for (int rnd = 0; rnd < 6; rnd++) begin
         do_reset();
         cfg_burst_len = LW'($urandom_range(0, 5));
         nextw = DW'(rnd) << 16;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) begin
               push(nextw);
               nextw = nextw + 1;
            end
            enable      = ($urandom_range(0, 7) != 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            cnt_clear   = ($urandom_range(0, 63) == 0);
            step();
         end
         cnt_clear = 1'b0;
         enable = 1'b1;
         drain($sformatf("rand%0d", rnd), 200, 2);
         step();
         check_counters($sformatf("rand%0d", rnd));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
